// File: rtl/seg7_to_bin_dec_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit6=a .. bit0=g),
// digit widths and the payload types used by the seven-segment decoder.
package seg7_to_bin_dec_pkg;

  localparam int unsigned DIGIT_W    = 7;
  localparam int unsigned NUM_DIGITS = 10;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned VALUE_W    = 7;
  localparam int unsigned S_DATA_W   = 2 * DIGIT_W;
  localparam int unsigned ERR_CNT_W  = 16;

  typedef logic [DIGIT_W-1:0] seg_code_t;

  localparam seg_code_t BLANK = 7'b1111111;

  // Entry i is the active-low pattern that lights decimal digit i.
  localparam logic [NUM_DIGITS-1:0][DIGIT_W-1:0] SEG_TABLE = {
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // Two-digit beat as carried on s_data: tens in the upper half.
  typedef struct packed {
    seg_code_t tens;
    seg_code_t ones;
  } seg_pair_t;

  // Decoded beat headed for the output register.
  typedef struct packed {
    logic               err;
    logic [VALUE_W-1:0] value;
  } dec_beat_t;

  // Encoder counterpart of the decoder; anything above 9 shows blank.
  function automatic seg_code_t seg7_encode(input logic [BCD_W-1:0] digit);
    seg_code_t code;
    code = BLANK;
    if (digit < BCD_W'(NUM_DIGITS)) begin
      code = SEG_TABLE[digit];
    end
    return code;
  endfunction

endpackage

// File: rtl/seg7_to_bin_dec_digit_dec.sv
// Combinational single-digit decoder: active-low segment code to BCD digit,
// flagging any pattern that is not in the shared segment table.
module seg7_digit_dec
  import seg7_to_bin_dec_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [BCD_W-1:0]   digit_c,
  output logic               invalid_c
);

  // Table search; codes are unique so at most one entry matches.
  always_comb begin
    digit_c   = '0;
    invalid_c = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (code == SEG_TABLE[BCD_W'(i)]) begin
        digit_c   = BCD_W'(i);
        invalid_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_to_bin_dec.sv
// Two-digit 7-segment to binary decoder with AXI-Stream handshakes and a
// two-stage pipeline (raw capture, then decoded output register).
module seg7_to_bin_dec
  import seg7_to_bin_dec_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [S_DATA_W-1:0]  s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [W-1:0]         m_data,
  output logic                 m_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  if (W < 7 || W > 32) begin : g_bad_width
    $error("seg7_to_bin_dec: W must be within 7..32");
  end

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  logic             s1_valid;
  seg_pair_t        s1_data;
  logic             s1_load_c;
  logic             s2_load_c;
  logic [BCD_W-1:0] tens_c;
  logic [BCD_W-1:0] ones_c;
  logic             tens_bad_c;
  logic             ones_bad_c;
  dec_beat_t        dec_c;

  seg7_digit_dec u_dec_tens (
    .code      (s1_data.tens),
    .digit_c   (tens_c),
    .invalid_c (tens_bad_c)
  );

  seg7_digit_dec u_dec_ones (
    .code      (s1_data.ones),
    .digit_c   (ones_c),
    .invalid_c (ones_bad_c)
  );

  // Stage 2 drains into the sink or is empty; stage 1 frees as it advances.
  always_comb begin
    s2_load_c = s1_valid && (!m_valid || m_ready);
    s_ready   = aresetn && (!s1_valid || s2_load_c);
    s1_load_c = s_valid && s_ready;
  end

  // Any undecodable digit zeroes the value.
  always_comb begin
    dec_c.err   = tens_bad_c || ones_bad_c;
    dec_c.value = '0;
    if (!dec_c.err) begin
      dec_c.value = VALUE_W'(tens_c) * VALUE_W'(4'd10) + VALUE_W'(ones_c);
    end
  end

  // Stage 1: raw segment capture.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (s1_load_c) begin
      s1_valid <= 1'b1;
      s1_data  <= seg_pair_t'(s_data);
    end else if (s2_load_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register, held while the sink stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= 1'b0;
    end else if (s2_load_c) begin
      m_valid <= 1'b1;
      m_data  <= W'(dec_c.value);
      m_err   <= dec_c.err;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Saturating count of error beats actually handed downstream.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_cnt <= '0;
    end else if (m_valid && m_ready && m_err && (err_cnt != ERR_CNT_MAX)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seg7_to_bin_dec.sv
// Scoreboard bench for seg7_to_bin_dec: accepted beats push the reference
// result, a negedge monitor pops and compares each delivered beat.
module tb_seg7_to_bin_dec;

  localparam int unsigned W = 16;
  localparam logic [6:0] BLANK_T = 7'b1111111;
  localparam logic [6:0] SEG_LIST [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  typedef struct packed {
    logic        err;
    logic [15:0] value;
  } exp_t;

  logic         aclk;
  logic         aresetn;
  logic         s_valid;
  logic         s_ready;
  logic [13:0]  s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_err;
  logic [15:0]  err_cnt;

  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_acc    = 0;
  int          n_out    = 0;
  int          cyc      = 0;
  int          rdy_mode = 2;
  logic [15:0] model_cnt = '0;
  logic        hold_pending = 1'b0;
  logic [W-1:0] held_data;
  logic        held_err;
  logic        bp_done;

  seg7_to_bin_dec #(.W(W)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_err   (m_err),
    .err_cnt (err_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got event expected none (t=%0t)", name, $time);
  endtask

  function automatic int lookup(input logic [6:0] c);
    for (int i = 0; i < 10; i++) if (SEG_LIST[i] == c) return i;
    return -1;
  endfunction

  // Reference: a two-digit decimal number, or an error with value 0.
  function automatic exp_t model(input logic [13:0] d);
    exp_t e;
    int   t;
    int   o;
    t = lookup(d[13:7]);
    o = lookup(d[6:0]);
    if (t < 0 || o < 0) begin
      e.err   = 1'b1;
      e.value = '0;
    end else begin
      e.err   = 1'b0;
      e.value = 16'(t * 10 + o);
    end
    return e;
  endfunction

  function automatic logic [13:0] enc2(input int tens, input int ones);
    return {SEG_LIST[tens], SEG_LIST[ones]};
  endfunction

  // Sink readiness pattern, updated just after each rising edge.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  always @(negedge aclk) begin
    if (aresetn && s_valid && s_ready) begin
      exp_q.push_back(model(s_data));
      n_acc++;
    end
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(held_data));
        check("hold_err", 32'(m_err), 32'(held_err));
      end
      if (m_valid && m_ready) begin
        exp_t e;
        check("err_cnt_run", 32'(err_cnt), 32'(model_cnt));
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e.value));
          check("m_err", 32'(m_err), 32'(e.err));
          if (e.err && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        end
        n_out++;
      end
      hold_pending = m_valid && !m_ready;
      held_data    = m_data;
      held_err     = m_err;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after acceptance.
  task automatic send(input logic [13:0] d, input int gaps);
    int waited;
    s_valid = 1'b0;
    repeat (gaps) begin
      @(posedge aclk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    waited  = 0;
    forever begin
      @(negedge aclk);
      if (s_ready) break;
      waited++;
      if (waited > 200) begin
        fail_now("send_timeout");
        break;
      end
      @(posedge aclk);
      #1;
    end
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    rdy_mode = 0;
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(posedge aclk);
      k++;
    end
    repeat (2) @(posedge aclk);
    #1;
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int c0;
    int o0;
    int k;
    aresetn = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_err", 32'(m_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_s_ready", 32'(s_ready), 32'd1);
    @(posedge aclk);
    #1;

    // "29": exactly two cycles of latency and a single valid pulse
    rdy_mode = 0;
    @(posedge aclk);
    #1;
    send(enc2(2, 9), 0);
    @(negedge aclk);
    check("lat_cycle1_valid", 32'(m_valid), 32'd0);
    @(negedge aclk);
    check("lat_cycle2_valid", 32'(m_valid), 32'd1);
    check("lat_cycle2_data", 32'(m_data), 32'd29);
    @(negedge aclk);
    check("single_pulse", 32'(m_valid), 32'd0);
    @(posedge aclk);
    #1;

    // 0..99 back to back at full rate
    c0 = cyc;
    for (int v = 0; v < 100; v++) send(enc2(v / 10, v % 10), 0);
    check("sweep_throughput", 32'(cyc - c0), 32'd100);
    drain();
    check("sweep_err_cnt", 32'(err_cnt), 32'd0);

    // blank ones digit
    send({SEG_LIST[0], BLANK_T}, 0);
    drain();
    check("blank_err_cnt", 32'(err_cnt), 32'd1);

    // sink stalled for 5 cycles with 3 beats offered
    rdy_mode = 2;
    repeat (2) @(posedge aclk);
    #1;
    a0 = n_acc;
    bp_done = 1'b0;
    fork
      begin
        send(enc2(4, 2), 0);
        send({BLANK_T, SEG_LIST[7]}, 0);
        send(enc2(9, 9), 0);
        bp_done = 1'b1;
      end
    join_none
    repeat (5) @(negedge aclk);
    check("bp_accepted", 32'(n_acc - a0), 32'd2);
    check("bp_s_ready", 32'(s_ready), 32'd0);
    rdy_mode = 0;
    k = 0;
    while (!bp_done && k < 300) begin
      @(posedge aclk);
      k++;
    end
    check("bp_all_sent", 32'(bp_done), 32'd1);
    #1;
    drain();

    // random digits, bubbles and sink stalls
    rdy_mode = 1;
    for (int n = 0; n < 400; n++) begin
      logic [6:0] t;
      logic [6:0] o;
      t = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SEG_LIST[$urandom_range(0, 9)];
      o = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SEG_LIST[$urandom_range(0, 9)];
      send({t, o}, int'($urandom_range(0, 2)));
    end
    drain();
    check("rand_err_cnt", 32'(err_cnt), 32'(model_cnt));

    // reset with both stages full: everything in flight is discarded
    rdy_mode = 2;
    repeat (2) @(posedge aclk);
    #1;
    send(enc2(1, 1), 0);
    send(enc2(2, 2), 0);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    exp_q.delete();
    model_cnt = '0;
    rdy_mode = 0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    o0 = n_out;
    repeat (10) @(posedge aclk);
    #1;
    check("no_stale_beats", 32'(n_out - o0), 32'd0);

    // err_cnt saturation
    for (int n = 0; n < 65534; n++) send({BLANK_T, BLANK_T}, 0);
    drain();
    check("sat_fffe", 32'(err_cnt), 32'hFFFE);
    for (int n = 0; n < 3; n++) send({SEG_LIST[3], BLANK_T}, 0);
    drain();
    check("sat_ffff", 32'(err_cnt), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_to_bin_dec.md
SEG7_TO_BIN_DEC -- requirements
Module: seg7_to_bin_dec

Interface
REQ-001 Parameter W, default 16, SHALL set the output binary value width; legal range 7..32.
REQ-002 aclk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 aresetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 s_valid  input  1  SHALL mark s_data as valid (AXI-Stream slave).
REQ-005 s_ready  output  1  SHALL indicate the block accepts s_data this cycle.
REQ-006 s_data  input  14  SHALL carry two active-low 7-segment digits: [6:0] ones, [13:7] tens; within each digit bit6=a ... bit0=g.
REQ-007 m_valid  output  1  SHALL mark m_data/m_err as valid (AXI-Stream master).
REQ-008 m_ready  input  1  SHALL indicate the downstream sink accepts the output.
REQ-009 m_data  output  W  SHALL carry the decoded binary value, zero-extended.
REQ-010 m_err  output  1  SHALL flag an undecodable digit in the associated beat.
REQ-011 err_cnt  output  16  SHALL count error beats delivered at the output.

Function
REQ-012 Digit table SHALL be 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-013 Any other 7-bit pattern, including blank 1111111, SHALL be an invalid digit.
REQ-014 Both digits valid: m_data SHALL equal tens*10 + ones (range 0..99) and m_err SHALL be 0.
REQ-015 Either digit invalid: m_data SHALL be 0 and m_err SHALL be 1.
REQ-016 Transfer SHALL occur on s_valid&&s_ready (input) and m_valid&&m_ready (output).
REQ-017 Datapath SHALL be a two-stage pipeline: stage 1 registers raw s_data, stage 2 registers decoded value, error flag and valid.
REQ-018 Latency SHALL be 2 cycles from input acceptance to m_valid with no backpressure.
REQ-019 Throughput SHALL be one beat per cycle while m_ready stays high.
REQ-020 Stage 2 SHALL load when stage 1 is valid and (stage 2 empty or m_ready); stage 1 SHALL load when s_valid and (stage 1 empty or it advances this cycle).
REQ-021 s_ready SHALL be high when stage 1 is empty or advances this cycle.
REQ-022 m_valid, m_data and m_err SHALL stay stable while m_valid && !m_ready.
REQ-023 No beat SHALL be dropped, duplicated or reordered.
REQ-024 Upstream backpressure: s_valid low SHALL insert bubbles; m_valid SHALL drop when stage 2 drains.
REQ-025 err_cnt SHALL increment by 1 on each output transfer with m_err=1 and saturate at 0xFFFF.
REQ-026 m_data SHALL be output-registered; s_ready MAY depend combinationally on m_ready.

Reset
REQ-027 aresetn low SHALL asynchronously clear both stage valids, m_valid=0, m_data=0, m_err=0, err_cnt=0.
REQ-028 s_ready SHALL be 0 during reset and 1 in the first cycle after deassertion.
REQ-029 Reset mid-transfer SHALL discard all in-flight beats; none SHALL appear after release.
REQ-030 Reset deassertion SHALL be synchronised to aclk externally; the block requires no internal synchroniser.

Structure
REQ-031 A shared package SHALL hold the 10-entry segment-code constant table, the BLANK code 7'b1111111, and the digit-width constant 7.
REQ-032 One sub-module, seg7_digit_dec (7-bit code in -> 4-bit digit + invalid flag, combinational), SHALL be instantiated twice.
REQ-033 The segment table SHALL be the same package constant used by the existing binary-to-7-segment encoder, guaranteeing round-trip consistency.

Verification
REQ-034 s_data={tens=0010010, ones=0000100} ("29"), m_ready=1 -> two cycles later m_data=29, m_err=0, one m_valid pulse.
REQ-035 Back-to-back 0..99 encoded by the team encoder, m_ready=1 -> m_data matches 0..99 in order, one per cycle, err_cnt=0.
REQ-036 ones=1111111, tens=0000001 -> m_data=0, m_err=1, err_cnt=1 after transfer.
REQ-037 m_ready low 5 cycles with 3 beats offered -> s_ready drops after 2 accepted, outputs stable, all 3 delivered in order once m_ready=1.
REQ-038 Force err_cnt to 0xFFFE via 65534 error beats then 3 more -> err_cnt holds 0xFFFF.
REQ-039 aresetn pulsed low while both stages full -> m_valid=0 immediately, err_cnt=0, no stale beat emitted after release.
